nx_ctrl_arbiter: RTL

- Shares the single nx_control host command port between REQUESTERS independent command sources, for example the host link and an on-chip debug sequencer.
- Arbitrates inbound nx_ctrl_req_t messages round-robin and forwards them one at a time.
- Tracks which requester issued each response-producing command, and routes each nx_ctrl_resp_t back to that requester in order.
- Sits directly between the requesters and nx_control.

---
 rtl/nx_ctrl_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/nx_ctrl_arbiter.sv
// nx_ctrl_arbiter: shares the nx_control command port between requesters and
// routes responses back in order. Macro NX_CTRL_ARB_PRIORITY_EN gives requester 0 priority.
`ifndef NX_MESSAGE_WIDTH
`define NX_MESSAGE_WIDTH 32
`endif

module nx_ctrl_arbiter #(
    parameter int REQUESTERS  = 2,
    parameter int TRACK_DEPTH = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [REQUESTERS*`NX_MESSAGE_WIDTH-1:0] req_data_i,
    input  logic [REQUESTERS-1:0]                  req_valid_i,
    output logic [REQUESTERS-1:0]                  req_ready_o,
    output logic [`NX_MESSAGE_WIDTH-1:0]           resp_data_o,
    output logic [REQUESTERS-1:0]                  resp_valid_o,
    input  logic [REQUESTERS-1:0]                  resp_ready_i,
    output logic [`NX_MESSAGE_WIDTH-1:0]           ctrl_req_data_o,
    output logic                                   ctrl_req_valid_o,
    input  logic                                   ctrl_req_ready_i,
    input  logic [`NX_MESSAGE_WIDTH-1:0]           ctrl_resp_data_i,
    input  logic                                   ctrl_resp_valid_i,
    output logic                                   ctrl_resp_ready_o,
    output logic [$clog2(TRACK_DEPTH+1)-1:0]       pending_o,
    output logic                                   err_orphan_o
);

    localparam int MW = `NX_MESSAGE_WIDTH;
    localparam int IW = $clog2(REQUESTERS);
    localparam int PW = $clog2(TRACK_DEPTH);
    localparam int CW = $clog2(TRACK_DEPTH+1);

    // nx_ctrl_req_t carries its command in the top three bits
    typedef enum logic [2:0] {
        NX_CTRL_ID       = 3'd0,
        NX_CTRL_VERSION  = 3'd1,
        NX_CTRL_PARAM    = 3'd2,
        NX_CTRL_ACTIVE   = 3'd3,
        NX_CTRL_STATUS   = 3'd4,
        NX_CTRL_CYCLES   = 3'd5,
        NX_CTRL_INTERVAL = 3'd6,
        NX_CTRL_UNKNOWN  = 3'd7
    } nx_ctrl_command_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic expects_resp(input nx_ctrl_command_t cmd);
        case (cmd)
            NX_CTRL_ID, NX_CTRL_VERSION, NX_CTRL_PARAM,
            NX_CTRL_STATUS, NX_CTRL_CYCLES: expects_resp = 1'b1;
            default:                        expects_resp = 1'b0;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   fifo_q [TRACK_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   count_q;
    logic            err_q;

    logic [MW-1:0]   slice [REQUESTERS];
    logic            cand_found;
    logic [IW-1:0]   cand_idx;
    int              idx;
    logic            fwd_valid;
    logic [IW-1:0]   fwd_idx;
    logic [MW-1:0]   fwd_data;
    logic            grant;
    logic            push;
    logic            pop;
    logic            orphan;
    logic            full;
    logic            empty;
    logic [IW-1:0]   head;

    assign full  = (count_q == CW'(TRACK_DEPTH));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_q];

    always_comb begin
        for (int r = 0; r < REQUESTERS; r++) begin
            slice[r] = req_data_i[r*MW +: MW];
        end
    end

    // Rotating search starting just after the last requester served
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        idx        = 0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            idx = (int'(last_q) + k) % REQUESTERS;
            if (!cand_found && req_valid_i[idx]) begin
                cand_found = 1'b1;
                cand_idx   = IW'(idx);
            end
        end
`ifdef NX_CTRL_ARB_PRIORITY_EN
        if (req_valid_i[0]) begin
            cand_found = 1'b1;
            cand_idx   = '0;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        fwd_valid = 1'b0;
        fwd_idx   = cand_idx;
        grant     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!full && cand_found) begin
                    fwd_valid = 1'b1;
                    if (ctrl_req_ready_i) begin
                        grant  = 1'b1;
                        last_d = cand_idx;
                    end else begin
                        owner_d = cand_idx;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                fwd_valid = 1'b1;
                fwd_idx   = owner_q;
                if (ctrl_req_ready_i) begin
                    grant   = 1'b1;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        fwd_data = slice[fwd_idx];
        push = grant && expects_resp(nx_ctrl_command_t'(fwd_data[MW-1 -: 3]));
    end

    always_comb begin
        req_ready_o      = '0;
        ctrl_req_valid_o = 1'b0;
        ctrl_req_data_o  = '0;
        if (rst_i) begin
            ctrl_req_valid_o = fwd_valid;
            ctrl_req_data_o  = fwd_data;
            req_ready_o[fwd_idx] = grant;
        end
    end

    // An empty tracker swallows stray responses and flags them
    always_comb begin
        resp_valid_o      = '0;
        resp_data_o       = '0;
        ctrl_resp_ready_o = 1'b0;
        pop               = 1'b0;
        orphan            = 1'b0;
        if (rst_i) begin
            resp_data_o = ctrl_resp_data_i;
            if (empty) begin
                ctrl_resp_ready_o = 1'b1;
                orphan            = ctrl_resp_valid_i;
            end else begin
                resp_valid_o[head] = ctrl_resp_valid_i;
                ctrl_resp_ready_o  = resp_ready_i[head];
                pop = ctrl_resp_valid_i && resp_ready_i[head];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= IW'(REQUESTERS-1);
            owner_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
            err_q   <= err_q | orphan;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_q] <= fwd_idx;
    end

    assign pending_o    = count_q;
    assign err_orphan_o = err_q;

    // A grant is only locked while the tracker still has room
    a_locked_not_full: assert property (
        @(posedge clk_i) disable iff (!rst_i) !(state_q == LOCKED && full)
    );

endmodule
